// File: rtl/csa_pkg.sv
// csa_pkg: shared types and sizing helper for the pipelined carry-select adder
package csa_pkg;
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
  } ctl_t;
  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction
endpackage

// File: rtl/csa_segment.sv
// csa_segment: combinational carry-select slice, both carry forms computed in parallel
module csa_segment #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [SEG_W:0] r0, r1;
  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + (SEG_W+1)'(1);
  assign {co, s} = ci ? r1 : r0;
  assign c_msb_in = a[SEG_W-1] ^ b[SEG_W-1] ^ s[SEG_W-1];
endmodule

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-select adder/subtractor, one segment per stage, valid/ready
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = nseg(WIDTH, SEG_W);
  if (SEG_W < 1 || SEG_W > WIDTH || WIDTH % SEG_W != 0) begin : g_bad
    $error("csa_pipe_adder: WIDTH must be a positive multiple of SEG_W");
  end
  // operands shift down one segment per stage; result segments shift in from the top
  typedef struct packed {
    ctl_t             ctl;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
  } stage_t;
  stage_t          pre [NSEG+1];
  logic [NSEG-1:0] co, cm;
  logic            en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign pre[0] = '{ctl: '{valid: in_valid, carry: sub ^ cin, sub: sub},
                    a_hi: a, b_hi: sub ? ~b : b, sum_lo: '0};
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W-1:0] s;
    stage_t           q;
    csa_segment #(.SEG_W(SEG_W)) u_seg (
      .a(pre[k].a_hi[SEG_W-1:0]),
      .b(pre[k].b_hi[SEG_W-1:0]),
      .ci(pre[k].ctl.carry),
      .s(s),
      .co(co[k]),
      .c_msb_in(cm[k])
    );
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (en) q <= '{ctl: '{valid: pre[k].ctl.valid, carry: co[k], sub: pre[k].ctl.sub},
                         a_hi: pre[k].a_hi >> SEG_W, b_hi: pre[k].b_hi >> SEG_W,
                         sum_lo: (pre[k].sum_lo >> SEG_W) | (WIDTH'(s) << (WIDTH - SEG_W))};
    assign pre[k+1] = q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (en) ovf <= co[NSEG-1] ^ cm[NSEG-1];
  assign out_valid = pre[NSEG].ctl.valid;
  assign sum = pre[NSEG].sum_lo;
  assign cout = pre[NSEG].ctl.carry;
  logic unused_bits;
  assign unused_bits = ^{pre[NSEG].a_hi, pre[NSEG].b_hi, pre[NSEG].ctl.sub, cm};
endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb_csa_pipe_adder: scoreboard bench driving 64/8, 32/4 and 16/16 instances in lockstep
module tb_csa_pipe_adder;
  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } exp_t;
  logic        clk, rst, vld, ordy, cin, sub;
  logic [63:0] a, b;
  logic        r64, r32, r16, ov64, ov32, ov16, co64, co32, co16, of64, of32, of16;
  logic [63:0] s64;
  logic [31:0] s32;
  logic [15:0] s16;
  exp_t        q64[$], q32[$], q16[$];
  int          checks = 0, errors = 0;

  csa_pipe_adder #(.WIDTH(64), .SEG_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(vld), .in_ready(r64), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov64), .out_ready(ordy), .sum(s64), .cout(co64), .ovf(of64));
  csa_pipe_adder #(.WIDTH(32), .SEG_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(vld), .in_ready(r32), .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(ordy), .sum(s32), .cout(co32), .ovf(of32));
  csa_pipe_adder #(.WIDTH(16), .SEG_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(vld), .in_ready(r16), .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(ordy), .sum(s16), .cout(co16), .ovf(of16));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib,
                                 input logic ic, input logic is, input int w);
    logic [64:0] m, am, bm, r;
    exp_t e;
    m = (65'd1 << w) - 65'd1;
    am = {1'b0, ia} & m;
    bm = {1'b0, is ? ~ib : ib} & m;
    r = am + bm + {64'd0, is ? ~ic : ic};
    e.s = r[63:0] & m[63:0];
    e.co = r[w];
    e.ov = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    return e;
  endfunction

  // called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic ic, input logic is,
                       input logic [63:0] es, input logic eco, input logic eov);
    int n = 0;
    a = ia; b = ib; cin = ic; sub = is; vld = 1;
    @(negedge clk);
    while (!(r64 && r32 && r16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("issue_timeout", 64'(n), 64'd0);
    q64.push_back('{s: es, co: eco, ov: eov});
    q32.push_back(model(ia, ib, ic, is, 32));
    q16.push_back(model(ia, ib, ic, is, 16));
    @(posedge clk);
    #1 vld = 0;
  endtask

  task automatic measure();
    int l64 = 0, l32 = 0, l16 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ov64 && l64 == 0) l64 = n;
      if (ov32 && l32 == 0) l32 = n;
      if (ov16 && l16 == 0) l16 = n;
    end
    chk("lat64", 64'(l64), 64'd8);
    chk("lat32", 64'(l32), 64'd8);
    chk("lat16", 64'(l16), 64'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst && ov64 && ordy) begin
      if (q64.size() == 0) chk("unexpected64", s64, 64'hx);
      else begin
        e = q64.pop_front();
        chk("sum64", s64, e.s);
        chk("cout64", 64'(co64), 64'(e.co));
        chk("ovf64", 64'(of64), 64'(e.ov));
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && ov32 && ordy) begin
      if (q32.size() == 0) chk("unexpected32", 64'(s32), 64'hx);
      else begin
        e = q32.pop_front();
        chk("sum32", 64'(s32), e.s);
        chk("cout32", 64'(co32), 64'(e.co));
        chk("ovf32", 64'(of32), 64'(e.ov));
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst && ov16 && ordy) begin
      if (q16.size() == 0) chk("unexpected16", 64'(s16), 64'hx);
      else begin
        e = q16.pop_front();
        chk("sum16", 64'(s16), e.s);
        chk("cout16", 64'(co16), 64'(e.co));
        chk("ovf16", 64'(of16), 64'(e.ov));
      end
    end
  end

  initial begin
    logic [63:0] cap;
    int n;
    rst = 1; vld = 0; ordy = 1; cin = 0; sub = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'({ov64, ov32, ov16}), 64'd0);
    chk("rst_in_ready", 64'({r64, r32, r16}), 64'h7);
    chk("rst_sum64", s64, 64'd0);
    chk("rst_flags64", 64'({co64, of64}), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1;
    issue(64'd2, 64'd5, 0, 0, 64'd7, 0, 0);
    measure();
    issue(64'd1, 64'd1, 0, 0, 64'd2, 0, 0);
    issue(64'd2223000, 64'd2021312300, 0, 0, 64'd2023535300, 0, 0);
    issue(64'd9213123, 64'd99812398123, 0, 0, 64'd99821611246, 0, 0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 64'd0, 1, 0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h8000_0000_0000_0000, 0, 1);
    issue(64'd20, 64'd20, 0, 1, 64'd0, 1, 0);
    issue(64'd5, 64'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
    issue(64'd75, 64'd75, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    issue(64'h8000_0000_0000_0000, 64'd1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1);
    repeat (12) @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 10; i++)
        issue(64'(i * 1000 + 5), 64'(i * 3 + 1), 0, 0, 64'(i * 1003 + 6), 0, 0);
      begin
        repeat (10) @(posedge clk);
        #1 ordy = 0;
        @(negedge clk);
        cap = s64;
        chk("stall_in_ready64", 64'(r64), 64'd0);
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready64", 64'(r64), 64'd0);
          chk("stall_valid64", 64'(ov64), 64'd1);
          chk("stall_sum64", s64, cap);
        end
        @(posedge clk);
        #1 ordy = 1;
      end
    join
    n = 0;
    while ((q64.size() + q32.size() + q16.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("stream_drained", 64'(q64.size() + q32.size() + q16.size()), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) issue(64'(i), 64'(i * 10), 0, 0, 64'(i * 11), 0, 0);
    rst = 1;
    #1;
    chk("midrst_out_valid", 64'({ov64, ov32, ov16}), 64'd0);
    q64.delete(); q32.delete(); q16.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'({ov64, ov32, ov16}), 64'd0);
    repeat (10) @(negedge clk);
    chk("no_stale_valid", 64'({ov64, ov32, ov16}), 64'd0);
    @(posedge clk);
    #1;
    issue(64'd1024, 64'd2048, 0, 0, 64'd3072, 0, 0);
    measure();
    n = 0;
    while ((q64.size() + q32.size() + q16.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("final_drained", 64'(q64.size() + q32.size() + q16.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
